// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit and the ALU
// control decoder that issues MULT/MULTU/DIV/DIVU requests to it.
package muldiv_pkg;

  localparam int MD_DATA_W = 32;
  localparam int MD_CNT_W  = 6;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } state_t;

  // Op-select encoding is {div_sel, Unsigned}
  localparam logic [1:0] MULT  = 2'b00;
  localparam logic [1:0] MULTU = 2'b01;
  localparam logic [1:0] DIV   = 2'b10;
  localparam logic [1:0] DIVU  = 2'b11;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Combinational two's-complement negation: either two independent W-bit
// values (operand magnitudes, quotient/remainder) or one 2W-bit product.
module muldiv_sign_fix
  import muldiv_pkg::*;
#(
  parameter int W = MD_DATA_W
) (
  input  logic         i_wide,
  input  logic [W-1:0] i_hi,
  input  logic [W-1:0] i_lo,
  input  logic         i_neg_hi,
  input  logic         i_neg_lo,
  output logic [W-1:0] o_hi,
  output logic [W-1:0] o_lo
);

  logic [2*W-1:0] w_full;
  logic [2*W-1:0] w_full_neg;
  logic [W-1:0]   w_hi_neg;
  logic [W-1:0]   w_lo_neg;

  assign w_full     = {i_hi, i_lo};
  assign w_full_neg = ~w_full + {{(2*W-1){1'b0}}, 1'b1};
  assign w_hi_neg   = ~i_hi + {{(W-1){1'b0}}, 1'b1};
  assign w_lo_neg   = ~i_lo + {{(W-1){1'b0}}, 1'b1};

  // In wide mode i_neg_hi negates the whole 2W-bit value as one number
  always_comb begin
    o_hi = i_hi;
    o_lo = i_lo;
    if (i_wide) begin
      if (i_neg_hi) begin
        o_hi = w_full_neg[2*W-1:W];
        o_lo = w_full_neg[W-1:0];
      end else begin
        o_hi = i_hi;
        o_lo = i_lo;
      end
    end else begin
      o_hi = i_neg_hi ? w_hi_neg : i_hi;
      o_lo = i_neg_lo ? w_lo_neg : i_lo;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider owning the HI/LO pair,
// with MTHI/MTLO writes and a busy output that stalls the pipeline.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_W = MD_DATA_W,
  parameter int CNT_W  = MD_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              div_sel,
  input  logic              Unsigned,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic              mthi,
  input  logic              mtlo,
  output logic [DATA_W-1:0] HI,
  output logic [DATA_W-1:0] LO,
  output logic              busy,
  output logic              done,
  output logic              div_zero
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_acc_hi;
  logic [DATA_W-1:0] r_acc_lo;
  logic [DATA_W-1:0] r_opb;
  logic [DATA_W-1:0] r_a_orig;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;
  logic              r_div;
  logic              r_neg_res;
  logic              r_neg_rem;
  logic              r_dz;
  logic              r_busy;
  logic              r_done;
  logic              r_div_zero;

  logic              w_neg_a;
  logic              w_neg_b;
  logic              w_res_neg_hi;
  logic [DATA_W-1:0] w_mag_a;
  logic [DATA_W-1:0] w_mag_b;
  logic [DATA_W-1:0] w_res_hi;
  logic [DATA_W-1:0] w_res_lo;
  logic [DATA_W-1:0] w_fin_hi;
  logic [DATA_W-1:0] w_fin_lo;
  logic [DATA_W-1:0] w_acc_hi_nxt;
  logic [DATA_W-1:0] w_acc_lo_nxt;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_shift;
  logic [DATA_W:0]   w_diff;
  logic              w_ge;

  assign w_neg_a = ~Unsigned & A[DATA_W-1];
  assign w_neg_b = ~Unsigned & B[DATA_W-1];

  muldiv_sign_fix #(.W(DATA_W)) u_opfix (
    .i_wide   (1'b0),
    .i_hi     (A),
    .i_lo     (B),
    .i_neg_hi (w_neg_a),
    .i_neg_lo (w_neg_b),
    .o_hi     (w_mag_a),
    .o_lo     (w_mag_b)
  );

  // Remainder follows the dividend sign; product/quotient follow the sign XOR
  assign w_res_neg_hi = r_div ? r_neg_rem : r_neg_res;

  muldiv_sign_fix #(.W(DATA_W)) u_resfix (
    .i_wide   (~r_div),
    .i_hi     (r_acc_hi),
    .i_lo     (r_acc_lo),
    .i_neg_hi (w_res_neg_hi),
    .i_neg_lo (r_neg_res),
    .o_hi     (w_res_hi),
    .o_lo     (w_res_lo)
  );

  assign w_sum   = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opb} : {(DATA_W+1){1'b0}});
  assign w_shift = {r_acc_hi, r_acc_lo[DATA_W-1]};
  assign w_diff  = w_shift - {1'b0, r_opb};
  // A shifted remainder with its top bit set always exceeds the divisor
  assign w_ge    = w_shift[DATA_W] | ~w_diff[DATA_W];

  assign w_fin_hi = r_dz ? r_a_orig : w_res_hi;
  assign w_fin_lo = r_dz ? {DATA_W{1'b1}} : w_res_lo;

  // One shift-add (multiply) or restoring shift-subtract (divide) step
  always_comb begin
    w_acc_hi_nxt = r_acc_hi;
    w_acc_lo_nxt = r_acc_lo;
    if (r_div) begin
      if (w_ge) begin
        w_acc_hi_nxt = w_diff[DATA_W-1:0];
        w_acc_lo_nxt = {r_acc_lo[DATA_W-2:0], 1'b1};
      end else begin
        w_acc_hi_nxt = w_shift[DATA_W-1:0];
        w_acc_lo_nxt = {r_acc_lo[DATA_W-2:0], 1'b0};
      end
    end else begin
      w_acc_hi_nxt = w_sum[DATA_W:1];
      w_acc_lo_nxt = {w_sum[0], r_acc_lo[DATA_W-1:1]};
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RUN: begin
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = FIX;
        end else begin
          w_state_nxt = RUN;
        end
      end
      FIX:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand latch, iteration datapath, HI/LO and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= {CNT_W{1'b0}};
      r_acc_hi   <= {DATA_W{1'b0}};
      r_acc_lo   <= {DATA_W{1'b0}};
      r_opb      <= {DATA_W{1'b0}};
      r_a_orig   <= {DATA_W{1'b0}};
      r_hi       <= {DATA_W{1'b0}};
      r_lo       <= {DATA_W{1'b0}};
      r_div      <= 1'b0;
      r_neg_res  <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_dz       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_busy     <= (w_state_nxt != IDLE);
      case (r_state)
        IDLE: begin
          if (mthi) begin
            r_hi <= A;
          end
          if (mtlo) begin
            r_lo <= A;
          end
          if (start) begin
            r_opb     <= div_sel ? w_mag_b : w_mag_a;
            r_acc_lo  <= div_sel ? w_mag_a : w_mag_b;
            r_acc_hi  <= {DATA_W{1'b0}};
            r_cnt     <= {CNT_W{1'b0}};
            r_div     <= div_sel;
            r_neg_res <= w_neg_a ^ w_neg_b;
            r_neg_rem <= w_neg_a;
            r_a_orig  <= A;
            r_dz      <= div_sel & (B == {DATA_W{1'b0}});
          end
        end
        RUN: begin
          r_acc_hi <= w_acc_hi_nxt;
          r_acc_lo <= w_acc_lo_nxt;
          r_cnt    <= r_cnt + CNT_ONE;
        end
        FIX: begin
          r_hi       <= w_fin_hi;
          r_lo       <= w_fin_lo;
          r_done     <= 1'b1;
          r_div_zero <= r_dz;
          r_cnt      <= {CNT_W{1'b0}};
        end
        default: begin
          r_cnt <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign HI       = r_hi;
  assign LO       = r_lo;
  assign busy     = r_busy;
  assign done     = r_done;
  assign div_zero = r_div_zero;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected HI/LO from a
// 64-bit arithmetic reference model; a monitor pops on every done pulse.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         div_sel = 1'b0;
  logic         Unsigned = 1'b0;
  logic         mthi = 1'b0;
  logic         mtlo = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [W-1:0] HI;
  logic [W-1:0] LO;
  logic         busy;
  logic         done;
  logic         div_zero;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  logic prev_done = 1'b0;

  muldiv_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .div_sel(div_sel), .Unsigned(Unsigned),
    .A(A), .B(B), .mthi(mthi), .mtlo(mtlo),
    .HI(HI), .LO(LO), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t ref_model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    longint sa, sb, q, r, p;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.dz = 1'b0;
    if (op == DIV || op == DIVU) begin
      if (b == 0) begin
        e.lo = '1;
        e.hi = a;
        e.dz = 1'b1;
      end else if (op == DIV) begin
        q = sa / sb;
        r = sa % sb;
        e.lo = q[31:0];
        e.hi = r[31:0];
      end else begin
        e.lo = a / b;
        e.hi = a % b;
      end
    end else if (op == MULT) begin
      p = sa * sb;
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else begin
      up = {32'h0, a} * {32'h0, b};
      e.hi = up[63:32];
      e.lo = up[31:0];
    end
    return e;
  endfunction

  // Present a request for one clock edge; caller guarantees busy=0 when push is set
  task automatic drive_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
    start = 1'b1;
    div_sel = op[1];
    Unsigned = op[0];
    A = a;
    B = b;
    if (push) sb_q.push_back(ref_model(op, a, b));
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < 100);
    chk({name, "_done_seen"}, done, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("idle_reached", busy, 0);
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk);
    #1;
    wait_idle();
    drive_op(op, a, b, 1'b1);
    wait_done(name);
  endtask

  // Scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        chk("done_single_cycle", prev_done, 0);
        chk("busy_low_in_done", busy, 0);
        chk("done_expected", sb_q.size() == 0, 0);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          chk("result_hi", HI, e.hi);
          chk("result_lo", LO, e.lo);
          chk("result_div_zero", div_zero, e.dz);
        end
      end
      if (div_zero === 1'b1) chk("div_zero_with_done", done, 1);
      prev_done = done;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    int t0;
    int dcnt;
    logic [1:0] op;
    logic [W-1:0] ra, rb;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_hi", HI, 0);
    chk("reset_lo", LO, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_div_zero", div_zero, 0);
    rst_n = 1'b1;

    // Latency and busy window on MULTU of max operands
    @(posedge clk);
    #1;
    drive_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      else break;
    end
    chk("busy_cycles", busy_cnt, 33);
    chk("done_at_busy_fall", done, 1);
    chk("multu_max_hi", HI, 32'hFFFF_FFFE);
    chk("multu_max_lo", LO, 32'h0000_0001);
    @(negedge clk);
    chk("done_cleared", done, 0);

    run_op("mult_neg", MULT, 32'hFFFF_FFFD, 32'd7);
    run_op("div_neg", DIV, 32'hFFFF_FFF9, 32'd2);
    run_op("divu_zero", DIVU, 32'd100, 32'd0);
    run_op("div_zero_signed", DIV, 32'h8000_0005, 32'd0);
    run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("mult_minneg", MULT, 32'h8000_0000, 32'h8000_0000);

    // start and mthi during busy are ignored
    @(posedge clk);
    #1;
    wait_idle();
    drive_op(MULTU, 32'd6, 32'd7, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    drive_op(DIVU, 32'd9, 32'd3, 1'b0);
    mthi = 1'b1;
    A = 32'h0000_1234;
    @(posedge clk);
    #1;
    mthi = 1'b0;
    wait_done("ignored_during_busy");
    chk("ignored_hi", HI, 0);
    chk("ignored_lo", LO, 42);
    @(posedge clk);
    #1;
    mtlo = 1'b1;
    A = 32'h0000_ABCD;
    @(posedge clk);
    #1;
    mtlo = 1'b0;
    chk("mtlo_lo", LO, 32'h0000_ABCD);
    chk("mtlo_hi_kept", HI, 0);
    mthi = 1'b1;
    mtlo = 1'b1;
    A = 32'h5A5A_A5A5;
    @(posedge clk);
    #1;
    mthi = 1'b0;
    mtlo = 1'b0;
    chk("mt_both_hi", HI, 32'h5A5A_A5A5);
    chk("mt_both_lo", LO, 32'h5A5A_A5A5);

    // MTHI together with start: write lands now, result overwrites later
    mthi = 1'b1;
    drive_op(MULTU, 32'hDEAD_BEEF, 32'd2, 1'b1);
    mthi = 1'b0;
    chk("mt_with_start_hi", HI, 32'hDEAD_BEEF);
    wait_done("mt_with_start");

    // Back-to-back: start asserted in the done cycle
    @(posedge clk);
    #1;
    drive_op(DIVU, 32'd1000, 32'd7, 1'b1);
    wait_done("b2b_first");
    t0 = cyc;
    drive_op(MULT, 32'hFFFF_FF00, 32'd3, 1'b1);
    wait_done("b2b_second");
    chk("b2b_spacing", cyc - t0, 34);

    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: ra = 32'h8000_0000;
        1: ra = 32'($urandom_range(0, 20));
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      run_op("random", op, ra, rb);
    end

    // Asynchronous reset in the middle of an operation
    run_op("pre_reset", MULTU, 32'hFFFF_FFFF, 32'd3);
    @(posedge clk);
    #1;
    drive_op(MULTU, 32'd123457, 32'd98765, 1'b1);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    chk("async_rst_hi", HI, 0);
    chk("async_rst_lo", LO, 0);
    chk("async_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done === 1'b1) dcnt++;
    end
    chk("no_done_after_reset", dcnt, 0);
    run_op("post_reset", DIV, 32'hFFFF_FF9C, 32'd7);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
